// File: rtl/alu_cmd_decoder.sv
// ALU command decoder: 5-bit opcode in, one-hot 6-bit ALU select out through a DEPTH-entry FIFO.
// Optional feature macro ALU_CMD_ERR_CNT_EN adds a saturating 8-bit illegal-opcode counter output.
module alu_cmd_decoder #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [4:0] in_opcode,
    output logic       in_ready,
    output logic [5:0] command,
    output logic       cmd_valid,
    input  logic       cmd_ready,
`ifdef ALU_CMD_ERR_CNT_EN
    output logic [7:0] err_count,
`endif
    output logic       illegal
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_VALID = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   rd_ptr, rd_ptr_nxt;
    logic [AW-1:0]   wr_ptr, wr_ptr_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic [2:0]      mem [DEPTH];
    logic [2:0]      head_idx_nxt;
    logic [5:0]      command_nxt;
    logic            legal, push, pop, rej;

    // Legal opcodes are 0..5; their low three bits double as the stored index.
    assign legal = (in_opcode[4:3] == 2'b00) && (in_opcode[2:0] < 3'd6);

    always_comb begin
        state_nxt    = state;
        rd_ptr_nxt   = rd_ptr;
        wr_ptr_nxt   = wr_ptr;
        count_nxt    = count;
        head_idx_nxt = 3'd0;
        command_nxt  = 6'b000000;

        push = in_valid && in_ready && legal;
        rej  = in_valid && in_ready && !legal;
        pop  = cmd_valid && cmd_ready;

        if (push) wr_ptr_nxt = wr_ptr + AW'(1);
        if (pop)  rd_ptr_nxt = rd_ptr + AW'(1);

        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase

        case (state)
            ST_EMPTY: if (push) state_nxt = ST_VALID;
            ST_VALID: if (pop && !push && (count == CW'(1))) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase

        // Next head may be the entry being written this very cycle.
        if (push && (rd_ptr_nxt == wr_ptr)) head_idx_nxt = in_opcode[2:0];
        else                                head_idx_nxt = mem[rd_ptr_nxt];

        if (state_nxt == ST_VALID) command_nxt = 6'(6'b000001 << head_idx_nxt);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_EMPTY;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            in_ready  <= 1'b1;
            cmd_valid <= 1'b0;
            command   <= 6'b000000;
            illegal   <= 1'b0;
        end else begin
            state     <= state_nxt;
            rd_ptr    <= rd_ptr_nxt;
            wr_ptr    <= wr_ptr_nxt;
            count     <= count_nxt;
            in_ready  <= (count_nxt < CW'(DEPTH));
            cmd_valid <= (state_nxt == ST_VALID);
            command   <= command_nxt;
            illegal   <= rej;
        end
    end

    // Storage needs no reset: count and pointers define which entries are live.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= in_opcode[2:0];
    end

`ifdef ALU_CMD_ERR_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                          err_count <= 8'd0;
        else if (rej && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_alu_cmd_decoder.sv
// Self-checking bench for alu_cmd_decoder: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_alu_cmd_decoder;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [4:0] in_opcode = 5'd0;
    logic       in_ready;
    logic [5:0] command;
    logic       cmd_valid;
    logic       cmd_ready = 1'b0;
    logic       illegal;
`ifdef ALU_CMD_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    int tests = 0;
    int fails = 0;

    int q[$];
    int exp_ill = 0;
    int exp_err = 0;

    alu_cmd_decoder #(.DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_opcode(in_opcode),
        .in_ready (in_ready),
        .command  (command),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
`ifdef ALU_CMD_ERR_CNT_EN
        .err_count(err_count),
`endif
        .illegal  (illegal)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] exp_cmd();
        if (q.size() == 0) return 6'b000000;
        return 6'(6'b000001 << q[0]);
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".in_ready"},  32'(in_ready),  32'(q.size() < DEPTH));
        chk({tag, ".cmd_valid"}, 32'(cmd_valid), 32'(q.size() != 0));
        chk({tag, ".command"},   32'(command),   32'(exp_cmd()));
        chk({tag, ".illegal"},   32'(illegal),   32'(exp_ill));
`ifdef ALU_CMD_ERR_CNT_EN
        chk({tag, ".err_count"}, 32'(err_count), 32'(exp_err));
`endif
    endtask

    // Drive one cycle of inputs, update the model at the edge, check at the next negedge.
    task automatic step(input string tag, input logic v, input logic [4:0] op, input logic rdy);
        bit acc, pop;
        in_valid  = v;
        in_opcode = op;
        cmd_ready = rdy;
        acc = v && (q.size() < DEPTH);
        pop = rdy && (q.size() > 0);
        @(posedge clock);
        if (pop) void'(q.pop_front());
        exp_ill = 0;
        if (acc) begin
            if (int'(op) <= 5) q.push_back(int'(op));
            else begin
                exp_ill = 1;
                if (exp_err < 255) exp_err++;
            end
        end
        @(negedge clock);
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        cmd_ready = 1'b0;
        q.delete();
        exp_ill = 0;
        exp_err = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check_all("reset");

        // Single sub opcode held until consumed
        step("sub_push", 1'b1, 5'd1, 1'b0);
        chk("sub_cmd", 32'(command), 32'(6'b000010));
        step("sub_hold1", 1'b0, 5'd0, 1'b0);
        step("sub_hold2", 1'b0, 5'd0, 1'b0);
        step("sub_pop", 1'b0, 5'd0, 1'b1);
        chk("sub_empty", 32'(command), 32'(6'b000000));

        // Underflow ignored
        step("underflow", 1'b0, 5'd0, 1'b1);

        // Fill to full, refused fifth offer, drain in order
        for (int i = 0; i < 4; i++) step("fill", 1'b1, 5'(i), 1'b0);
        chk("full_ready", 32'(in_ready), 32'(0));
        step("fifth", 1'b1, 5'd4, 1'b0);
        chk("fifth_count", 32'(q.size()), 32'(4));
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", 32'(command), 32'(6'(6'b000001 << i)));
            step("drain", 1'b0, 5'd0, 1'b1);
        end

        // Full with simultaneous offer and pop: pop only
        for (int i = 0; i < 4; i++) step("refill", 1'b1, 5'(5 - i), 1'b0);
        step("full_pushpop", 1'b1, 5'd0, 1'b1);
        chk("full_pushpop_ready", 32'(in_ready), 32'(1));
        chk("full_pushpop_cmd", 32'(command), 32'(6'b010000));
        for (int i = 0; i < 3; i++) step("drain2", 1'b0, 5'd0, 1'b1);

        // Illegal opcodes
        step("ill_6", 1'b1, 5'd6, 1'b0);
        chk("ill_pulse", 32'(illegal), 32'(1));
        step("ill_clear", 1'b0, 5'd0, 1'b0);
        step("ill_31", 1'b1, 5'd31, 1'b0);
        step("ill_8", 1'b1, 5'd8, 1'b0);
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'b1;
            in_opcode = 5'(6 + (i % 26));
            @(posedge clock);
            if (exp_err < 255) exp_err++;
            exp_ill = 1;
        end
        @(negedge clock);
        check_all("ill_sat");
        step("ill_after", 1'b0, 5'd0, 1'b0);

        // Steady stream through the FIFO
        step("stream_prime", 1'b1, 5'd0, 1'b0);
        for (int i = 1; i <= 14; i++) step("stream", 1'b1, 5'(i % 6), 1'b1);
        chk("stream_count", 32'(q.size()), 32'(1));
        step("stream_end", 1'b0, 5'd0, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step("rand", 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 2) == 0));

        // Asynchronous reset with entries queued
        while (q.size() > 0) step("pre_rst_drain", 1'b0, 5'd0, 1'b1);
        for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 5'(i + 2), 1'b0);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        q.delete();
        exp_ill = 0;
        exp_err = 0;
        check_all("async_rst");
        @(negedge clock);
        reset = 1'b0;
        check_all("post_rst");
        step("first_after_rst", 1'b1, 5'd5, 1'b0);
        chk("first_after_rst_cmd", 32'(command), 32'(6'b100000));
        step("final_pop", 1'b0, 5'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_cmd_decoder.md
ALU_CMD_DECODER -- requirements
Module: alu_cmd_decoder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: number of command FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the producer offers an opcode.
REQ-005 The block SHALL have port in_opcode, input, 5 bits: binary ALU opcode.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an opcode this cycle.
REQ-007 The block SHALL have port command, output, 6 bits: one-hot ALU select for the ALU result mux.
REQ-008 The block SHALL have port cmd_valid, output, 1 bit: command holds a pending command.
REQ-009 The block SHALL have port cmd_ready, input, 1 bit: the ALU consumes command this cycle.
REQ-010 The block SHALL have port illegal, output, 1 bit: one-cycle pulse flagging a rejected opcode.

Function
REQ-011 An input transfer SHALL occur on a rising edge only when in_valid=1 and in_ready=1.
REQ-012 An output transfer SHALL occur on a rising edge only when cmd_valid=1 and cmd_ready=1.
REQ-013 Decode map: 00000->command 000001 (add), 00001->000010 (sub), 00010->000100 (and), 00011->001000 (or), 00100->010000 (sll), 00101->100000 (sra).
REQ-014 Any other opcode SHALL be illegal; an illegal opcode completes its handshake, is not enqueued, and drives illegal=1 for exactly the following cycle.
REQ-015 Legal opcodes SHALL be stored as 3-bit indices in a FIFO of DEPTH entries, using wrapping read/write pointers and an occupancy count 0..DEPTH.
REQ-016 in_ready SHALL be 1 iff count<DEPTH, registered-state based only; no combinational path from cmd_ready to in_ready.
REQ-017 At full, a same-cycle pop SHALL NOT enable a push (in_ready stays 0 that cycle).
REQ-018 At count 1..DEPTH-1, a simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-019 cmd_valid SHALL be 1 iff count!=0; command SHALL be the one-hot decode of the head entry, and 6'b000000 when count=0.
REQ-020 Latency: a legal opcode accepted at edge N into an empty FIFO SHALL appear on command with cmd_valid=1 after edge N (visible in cycle N+1).
REQ-021 While cmd_valid=1 and cmd_ready=0, command SHALL hold stable.
REQ-022 command SHALL never have more than one bit set.
REQ-023 Output stage states: EMPTY (cmd_valid=0) -> VALID on push; VALID -> EMPTY on pop with count=1 and no push; VALID otherwise holds.
REQ-024 cmd_ready while cmd_valid=0 SHALL be ignored (no underflow; pointers unchanged).

Reset
REQ-025 reset=1 SHALL immediately, without waiting for clock, clear pointers and count, and force cmd_valid=0, command=000000, illegal=0, in_ready=1.
REQ-026 Reset asserted mid-operation SHALL discard all queued commands; no stale command SHALL appear after deassertion.
REQ-027 The first transfer SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-028 Macro ALU_CMD_ERR_CNT_EN SHALL, when defined, add output err_count (8 bits): incremented on each illegal opcode accepted, saturating at 255, and cleared by reset.
REQ-029 Without ALU_CMD_ERR_CNT_EN, the err_count port and counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 Reset, in_opcode=00001 with in_valid for one cycle and cmd_ready=0 -> next cycle cmd_valid=1, command=000010, held until cmd_ready=1, then cmd_valid=0, command=000000.
REQ-031 Push opcodes 0,1,2,3 with cmd_ready=0 (DEPTH=4) -> in_ready=0 after the 4th; a 5th offer is not accepted; with cmd_ready=1, outputs 000001, 000010, 000100, 001000 appear in order.
REQ-032 Full FIFO, in_valid=1 and cmd_ready=1 in the same cycle -> one pop, no push, count=3, in_ready=1 the next cycle.
REQ-033 in_opcode=00110 accepted -> illegal=1 for one cycle, FIFO unchanged; with ALU_CMD_ERR_CNT_EN, err_count increments 0->1; 300 illegal opcodes -> err_count=255.
REQ-034 Steady stream with in_valid=1, cmd_ready=1, and opcodes cycling 0..5 -> one command per cycle, count constant at 1, pointers wrap with no loss.
REQ-035 reset asserted between clock edges with 3 entries queued -> cmd_valid=0 and command=000000 immediately, in_ready=1.
